// File: rtl/operand_deserializer.sv
// -----------------------------------------------------------------------------
// operand_deserializer
//
// Serial-to-parallel operand front end for the multiplier under exploration.
// NUM_OPS serial lanes share one bit strobe and one bit counter. Each lane
// collects WIDTH bits, MSB first, into its own operand. Once all lanes hold a
// complete operand, the operands are presented with a valid/ready handshake
// and held stable until the consumer takes them. Framing problems are visible
// on two outputs: a sticky overrun flag for strobes dropped while holding, and
// a handshake counter. An abort input throws away the frame in progress.
//
// Ports
//   clk            clock
//   reset          synchronous, active-high reset (highest priority)
//   i_ser_in       serial data, lane i on bit i
//   i_ser_en       bit strobe; i_ser_in is sampled when high
//   i_abort        synchronous frame abort (below reset, above everything else)
//   i_out_ready    consumer accepts the presented operands
//   o_ops          operands, lane i at o_ops[i*WIDTH +: WIDTH]
//   o_out_valid    operands complete and stable (high exactly in HOLD)
//   o_bit_cnt      bits accepted in the current frame
//   o_overrun      sticky: a strobe arrived and was dropped while holding
//   o_frame_count  completed handshakes, wraps 255 -> 0
//
// All outputs are registered. No input reaches an output combinationally.
//
// State table
//   state  | meaning
//   S_LOAD | shifting in strobed bits; o_out_valid low; i_out_ready ignored
//   S_HOLD | operands complete and frozen; strobes dropped and flagged
// -----------------------------------------------------------------------------
module operand_deserializer #(
  parameter int WIDTH   = 8,
  parameter int NUM_OPS = 3,
  parameter int CNT_W   = $clog2(WIDTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_OPS-1:0]         i_ser_in,
  input  logic                       i_ser_en,
  input  logic                       i_abort,
  input  logic                       i_out_ready,
  output logic [NUM_OPS*WIDTH-1:0]   o_ops,
  output logic                       o_out_valid,
  output logic [CNT_W-1:0]           o_bit_cnt,
  output logic                       o_overrun,
  output logic [7:0]                 o_frame_count
);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  state_t                     r_state;
  logic [NUM_OPS*WIDTH-1:0]   r_ops;
  logic                       r_out_valid;
  logic [CNT_W-1:0]           r_bit_cnt;
  logic                       r_overrun;
  logic [7:0]                 r_frame_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_LOAD;
      r_ops         <= '0;
      r_out_valid   <= 1'b0;
      r_bit_cnt     <= '0;
      r_overrun     <= 1'b0;
      r_frame_count <= '0;
    end else if (i_abort) begin
      // Abort wipes the frame and the overrun flag. A strobe or ready in the
      // same cycle is ignored, so frame_count is left alone.
      r_state     <= S_LOAD;
      r_ops       <= '0;
      r_out_valid <= 1'b0;
      r_bit_cnt   <= '0;
      r_overrun   <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (i_ser_en) begin
            for (int i = 0; i < NUM_OPS; i++) begin
              r_ops[i*WIDTH +: WIDTH] <= {r_ops[i*WIDTH +: WIDTH-1], i_ser_in[i]};
            end
            if (r_bit_cnt == C_LAST_BIT) begin
              r_bit_cnt   <= '0;
              r_state     <= S_HOLD;
              r_out_valid <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + C_CNT_ONE;
            end
          end
        end
        S_HOLD: begin
          // A strobe here is lost even when the handshake completes in the
          // same cycle; it never becomes the first bit of the next frame.
          if (i_ser_en) begin
            r_overrun <= 1'b1;
          end
          if (i_out_ready) begin
            r_state       <= S_LOAD;
            r_out_valid   <= 1'b0;
            r_frame_count <= r_frame_count + 8'd1;
          end
        end
        default: begin
          r_state     <= S_LOAD;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_ops         = r_ops;
  assign o_out_valid   = r_out_valid;
  assign o_bit_cnt     = r_bit_cnt;
  assign o_overrun     = r_overrun;
  assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_operand_deserializer.sv
module tb_operand_deserializer;

  localparam int W  = 8;
  localparam int N  = 3;
  localparam int CW = $clog2(W);

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     i_ser_in;
  logic             i_ser_en;
  logic             i_abort;
  logic             i_out_ready;
  logic [N*W-1:0]   o_ops;
  logic             o_out_valid;
  logic [CW-1:0]    o_bit_cnt;
  logic             o_overrun;
  logic [7:0]       o_frame_count;

  operand_deserializer #(.WIDTH(W), .NUM_OPS(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_ser_in      (i_ser_in),
    .i_ser_en      (i_ser_en),
    .i_abort       (i_abort),
    .i_out_ready   (i_out_ready),
    .o_ops         (o_ops),
    .o_out_valid   (o_out_valid),
    .o_bit_cnt     (o_bit_cnt),
    .o_overrun     (o_overrun),
    .o_frame_count (o_frame_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: bits accepted in the current frame, whether complete
  // operands are being presented, the overrun flag and the handshake count.
  logic [N-1:0]   frame_bits[$];
  logic [N*W-1:0] sb[$];
  bit             m_hold;
  bit             m_ovr;
  int             m_fc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Operand value of each lane, built from the bit list MSB first.
  function automatic logic [N*W-1:0] frame_value();
    logic [N*W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      int acc;
      acc = 0;
      for (int k = 0; k < W; k++) acc = acc * 2 + int'(frame_bits[k][i]);
      v[i*W +: W] = W'(acc);
    end
    return v;
  endfunction

  task automatic model_step(input bit en, input logic [N-1:0] bits, input bit rdy, input bit ab);
    if (ab) begin
      m_hold = 0;
      m_ovr  = 0;
      frame_bits.delete();
    end else if (!m_hold) begin
      if (en) begin
        frame_bits.push_back(bits);
        if (frame_bits.size() == W) begin
          sb.push_back(frame_value());
          frame_bits.delete();
          m_hold = 1;
        end
      end
    end else begin
      if (en) m_ovr = 1;
      if (rdy) begin
        m_hold = 0;
        m_fc   = (m_fc + 1) % 256;
      end
    end
  endtask

  task automatic cycle(input bit en, input logic [N-1:0] bits, input bit rdy, input bit ab);
    i_ser_en    = en;
    i_ser_in    = bits;
    i_out_ready = rdy;
    i_abort     = ab;
    model_step(en, bits, rdy, ab);
    @(posedge clk);
    #1;
    chk("out_valid",   64'(o_out_valid),   64'(m_hold));
    chk("bit_cnt",     64'(o_bit_cnt),     64'(frame_bits.size()));
    chk("overrun",     64'(o_overrun),     64'(m_ovr));
    chk("frame_count", 64'(o_frame_count), 64'(m_fc));
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    i_ser_en    = 1'($urandom);
    i_ser_in    = N'($urandom);
    i_out_ready = 1'($urandom);
    i_abort     = 1'b0;
    m_hold = 0; m_ovr = 0; m_fc = 0;
    frame_bits.delete();
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_ops",         64'(o_ops),         64'd0);
    chk("rst_out_valid",   64'(o_out_valid),   64'd0);
    chk("rst_bit_cnt",     64'(o_bit_cnt),     64'd0);
    chk("rst_overrun",     64'(o_overrun),     64'd0);
    chk("rst_frame_count", 64'(o_frame_count), 64'd0);
  endtask

  // Strobe one full frame in; gaps of 1..max_gap idle cycles precede each bit
  // when max_gap > 0. out_ready is randomised during LOAD since it is ignored.
  task automatic send_frame(input logic [N*W-1:0] vals, input int max_gap);
    for (int k = 0; k < W; k++) begin
      logic [N-1:0] b;
      if (max_gap > 0) begin
        repeat ($urandom_range(1, max_gap)) cycle(0, N'($urandom), 1'($urandom), 0);
      end
      for (int i = 0; i < N; i++) b[i] = vals[i*W + (W-1-k)];
      cycle(1, b, 1'($urandom), 0);
    end
  endtask

  // Monitor: pops the scoreboard when operands are first presented and keeps
  // checking them for stability while they stay presented.
  logic [N*W-1:0] cur_exp;
  logic           prev_valid = 1'b0;
  always @(negedge clk) begin
    if (!reset && o_out_valid) begin
      if (!prev_valid) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_underflow: got valid with ops 0x%0h expected no frame", o_ops);
          cur_exp = o_ops;
        end else begin
          cur_exp = sb.pop_front();
          chk("sb_ops", 64'(o_ops), 64'(cur_exp));
        end
      end else begin
        chk("hold_stable", 64'(o_ops), 64'(cur_exp));
      end
    end
    prev_valid = reset ? 1'b0 : o_out_valid;
  end

  initial begin
    reset = 1'b1; i_ser_en = 0; i_ser_in = '0; i_out_ready = 0; i_abort = 0;
    @(posedge clk); #1;
    do_reset();

    // Basic frame: lane0 0xA5, lane1 0xFF, lane2 0x55.
    send_frame(24'h55FFA5, 0);
    chk("basic_valid", 64'(o_out_valid), 64'd1);
    chk("basic_ops",   64'(o_ops),       64'h55FFA5);
    chk("basic_cnt",   64'(o_bit_cnt),   64'd0);
    cycle(0, '0, 1, 0);

    // Gapped strobes with 5 cycles of backpressure.
    send_frame(24'h55FFA5, 3);
    repeat (5) begin
      cycle(0, N'($urandom), 0, 0);
      chk("bp_ops", 64'(o_ops), 64'h55FFA5);
    end
    cycle(0, '0, 1, 0);
    chk("bp_valid_low", 64'(o_out_valid),   64'd0);
    chk("bp_fc",        64'(o_frame_count), 64'd2);

    // Overrun: two dropped strobes while holding, then a clean frame.
    send_frame(24'h123456, 0);
    cycle(1, N'($urandom), 0, 0);
    cycle(1, N'($urandom), 0, 0);
    chk("ovr_set", 64'(o_overrun), 64'd1);
    cycle(0, '0, 1, 0);
    send_frame(24'h3C3C3C, 0);
    chk("ovr_ops",    64'(o_ops),     64'h3C3C3C);
    chk("ovr_sticky", 64'(o_overrun), 64'd1);

    // Simultaneous handshake and strobe.
    cycle(1, '1, 1, 0);
    chk("sim_cnt",   64'(o_bit_cnt),     64'd0);
    chk("sim_valid", 64'(o_out_valid),   64'd0);
    chk("sim_ovr",   64'(o_overrun),     64'd1);
    chk("sim_fc",    64'(o_frame_count), 64'd4);

    // Abort after 5 strobes, with a strobe in the abort cycle.
    repeat (5) cycle(1, N'($urandom), 0, 0);
    chk("abt_cnt5", 64'(o_bit_cnt), 64'd5);
    cycle(1, '1, 1, 1);
    chk("abt_cnt", 64'(o_bit_cnt), 64'd0);
    chk("abt_ops", 64'(o_ops),     64'd0);
    chk("abt_ovr", 64'(o_overrun), 64'd0);
    send_frame(24'h818181, 0);
    chk("abt_final_ops", 64'(o_ops),         64'h818181);
    chk("abt_fc_held",   64'(o_frame_count), 64'd4);
    cycle(0, '0, 1, 0);
    chk("abt_fc_inc", 64'(o_frame_count), 64'd5);

    // Randomised traffic including aborts, dropped strobes and backpressure.
    for (int c = 0; c < 3000; c++) begin
      cycle($urandom_range(0, 2) != 0, N'($urandom), $urandom_range(0, 3) == 0,
            $urandom_range(0, 99) == 0);
    end

    // Counter wrap after 256 handshakes, then reset mid-frame.
    do_reset();
    for (int f = 0; f < 256; f++) begin
      send_frame(N*W'($urandom), 0);
      cycle(0, '0, 1, 0);
      if (f == 254) chk("fc_255", 64'(o_frame_count), 64'd255);
    end
    chk("fc_wrap", 64'(o_frame_count), 64'd0);
    repeat (3) cycle(1, N'($urandom), 0, 0);
    chk("mid_cnt", 64'(o_bit_cnt), 64'd3);
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
